// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath/memory signal bundle for multicycle_ctrl
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             mem_req;
   logic             mem_write;
   logic             adr_src;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       inm_src;
   logic [1:0]       res_src;
   logic             reg_write;
   logic             csr_we;
   logic [1:0]       mocsr;
   logic             illegal;
   logic             bus_err;
   logic [CNT_W-1:0] instret;

   modport master (
      input  op, zero, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write,
             alu_src_a, alu_src_b, alu_op, inm_src, res_src,
             reg_write, csr_we, mocsr, illegal, bus_err, instret
   );

   modport slave (
      output op, zero, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write,
             alu_src_a, alu_src_b, alu_op, inm_src, res_src,
             reg_write, csr_we, mocsr, illegal, bus_err, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with memory timeout and retire counter
module multicycle_ctrl #(
   parameter bit ENABLE_CSR  = 1'b1,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master bus
);

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_RTYPE  = 7'd51;
   localparam logic [6:0] OP_ITYPE  = 7'd19;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JAL    = 7'd111;
   localparam logic [6:0] OP_SYSTEM = 7'd115;
   localparam int         WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_CSR, S_TRAP
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       fetch;
      logic       pc_update;
      logic       branch;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] res_src;
      logic       reg_write;
      logic       csr_we;
      logic [1:0] mocsr;
   } ctl_t;

   state_t            state_q, state_d;
   ctl_t              ctl_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              waiting;
   logic              timeout;
   logic              retire;

   function automatic ctl_t decode_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b10; c.res_src = 2'b10; end
         S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
         S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         S_MEMWB:    begin c.res_src = 2'b01; c.reg_write = 1'b1; end
         S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
         S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
         S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
         S_ALUWB:    c.reg_write = 1'b1;
         S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
         S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
         S_CSR:      begin c.res_src = 2'b11; c.reg_write = 1'b1; c.csr_we = 1'b1; c.mocsr = 2'b01; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      retire    = 1'b0;
      waiting   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      // The cycle on which the counter would reach MEM_TIMEOUT is the last chance for mem_ready.
      timeout   = (MEM_TIMEOUT > 0) && waiting && !bus.mem_ready &&
                  (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
      case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_SYSTEM:         state_d = ENABLE_CSR ? S_CSR : S_TRAP;
               default:           state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP) illegal_d = 1'b1;
         end
         S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: begin
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECR, S_EXECI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ, S_CSR: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
      if (timeout) begin
         state_d   = S_TRAP;
         bus_err_d = 1'b1;
      end

      wait_d = wait_q;
      if (state_d != state_q)
         wait_d = '0;
      else if (waiting && !bus.mem_ready && (MEM_TIMEOUT > 0))
         wait_d = wait_q + WAIT_W'(1);

      instret_d = instret_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ctl_q     <= decode_ctl(S_FETCH);
         wait_q    <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctl_q     <= decode_ctl(state_d);
         wait_q    <= wait_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      case (bus.op)
         OP_STORE:  bus.inm_src = 2'b01;
         OP_BRANCH: bus.inm_src = 2'b10;
         OP_JAL:    bus.inm_src = 2'b11;
         default:   bus.inm_src = 2'b00;
      endcase
   end

   assign bus.mem_req   = ctl_q.mem_req;
   assign bus.mem_write = ctl_q.mem_write;
   assign bus.adr_src   = ctl_q.adr_src;
   assign bus.ir_write  = ctl_q.fetch & bus.mem_ready;
   assign bus.pc_write  = (ctl_q.fetch & bus.mem_ready) | ctl_q.pc_update | (ctl_q.branch & bus.zero);
   assign bus.alu_src_a = ctl_q.alu_src_a;
   assign bus.alu_src_b = ctl_q.alu_src_b;
   assign bus.alu_op    = ctl_q.alu_op;
   assign bus.res_src   = ctl_q.res_src;
   assign bus.reg_write = ctl_q.reg_write;
   assign bus.csr_we    = ctl_q.csr_we;
   assign bus.mocsr     = ctl_q.mocsr;
   assign bus.illegal   = illegal_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (two parameter sets)
module tb_multicycle_ctrl;

   localparam int TMO_A = 4;
   localparam int CW_A  = 3;
   localparam int TMO_B = 0;
   localparam int CW_B  = 32;

   typedef struct packed {
      logic        mem_req;
      logic        mem_write;
      logic        adr_src;
      logic        ir_write;
      logic        pc_write;
      logic [1:0]  asa;
      logic [1:0]  asb;
      logic [1:0]  aluop;
      logic [1:0]  inm;
      logic [1:0]  res;
      logic        reg_write;
      logic        csr_we;
      logic [1:0]  mocsr;
      logic        illegal;
      logic        bus_err;
      logic [31:0] instret;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CW_A)) ia();
   multicycle_ctrl_if #(.CNT_W(CW_B)) ib();

   multicycle_ctrl #(.ENABLE_CSR(1'b1), .MEM_TIMEOUT(TMO_A), .CNT_W(CW_A)) dut_a (
      .clk(clk), .rst_n(rst_a), .bus(ia.master));
   multicycle_ctrl #(.ENABLE_CSR(1'b0), .MEM_TIMEOUT(TMO_B), .CNT_W(CW_B)) dut_b (
      .clk(clk), .rst_n(rst_b), .bus(ib.master));

   exp_t        qa[$];
   exp_t        qb[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          mc[2] = '{0, 0};
   bit [31:0]   ret[2] = '{0, 0};
   bit          ill[2] = '{0, 0};
   bit          berr[2] = '{0, 0};
   bit          csr_en[2] = '{1'b1, 1'b0};
   int          tmo[2] = '{TMO_A, TMO_B};
   int          cw[2] = '{CW_A, CW_B};
   logic [6:0]  cur_op[2] = '{7'd0, 7'd0};
   logic        cur_z[2] = '{1'b0, 1'b0};

   function automatic void check_exp(input string name, input exp_t got, input exp_t want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h required=%h", name, got, want);
   endfunction

   function automatic void check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%0d required=%0d", name, got, want);
   endfunction

   function automatic exp_t samp(input int w);
      exp_t g;
      g = '0;
      if (w == 0) begin
         g.mem_req = ia.mem_req;   g.mem_write = ia.mem_write; g.adr_src = ia.adr_src;
         g.ir_write = ia.ir_write; g.pc_write = ia.pc_write;   g.asa = ia.alu_src_a;
         g.asb = ia.alu_src_b;     g.aluop = ia.alu_op;        g.inm = ia.inm_src;
         g.res = ia.res_src;       g.reg_write = ia.reg_write; g.csr_we = ia.csr_we;
         g.mocsr = ia.mocsr;       g.illegal = ia.illegal;     g.bus_err = ia.bus_err;
         g.instret = 32'(ia.instret);
      end else begin
         g.mem_req = ib.mem_req;   g.mem_write = ib.mem_write; g.adr_src = ib.adr_src;
         g.ir_write = ib.ir_write; g.pc_write = ib.pc_write;   g.asa = ib.alu_src_a;
         g.asb = ib.alu_src_b;     g.aluop = ib.alu_op;        g.inm = ib.inm_src;
         g.res = ib.res_src;       g.reg_write = ib.reg_write; g.csr_we = ib.csr_we;
         g.mocsr = ib.mocsr;       g.illegal = ib.illegal;     g.bus_err = ib.bus_err;
         g.instret = ib.instret;
      end
      return g;
   endfunction

   always @(negedge clk) begin
      if (qa.size() > 0) begin
         mc[0]++;
         check_exp($sformatf("A_cycle%0d", mc[0]), samp(0), qa.pop_front());
      end
      if (qb.size() > 0) begin
         mc[1]++;
         check_exp($sformatf("B_cycle%0d", mc[1]), samp(1), qb.pop_front());
      end
   end

   function automatic logic [1:0] inm_of(input logic [6:0] op);
      case (op)
         7'd35:   return 2'b01;
         7'd99:   return 2'b10;
         7'd111:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic exp_t base(input int w);
      exp_t e;
      e = '0;
      e.inm = inm_of(cur_op[w]);
      e.illegal = ill[w];
      e.bus_err = berr[w];
      e.instret = ret[w];
      return e;
   endfunction

   function automatic void retire(input int w);
      ret[w] = ret[w] + 32'd1;
      if (cw[w] < 32) ret[w] = ret[w] & ((32'd1 << cw[w]) - 32'd1);
   endfunction

   function automatic int qsize(input int w);
      return (w == 0) ? qa.size() : qb.size();
   endfunction

   task automatic drive(input int w, input logic rdy);
      if (w == 0) begin
         ia.op = cur_op[0]; ia.zero = cur_z[0]; ia.mem_ready = rdy;
      end else begin
         ib.op = cur_op[1]; ib.zero = cur_z[1]; ib.mem_ready = rdy;
      end
   endtask

   // Called at posedge+1: drive this cycle's inputs, queue its expectation, advance one clock.
   task automatic cyc(input int w, input logic rdy, input exp_t e);
      drive(w, rdy);
      if (w == 0) qa.push_back(e);
      else qb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(input int w, input int wt, input exp_t e, input bit is_fetch, output bit ok);
      exp_t ee;
      ok = 1'b0;
      for (int k = 1; k <= wt + 1; k++) begin
         ee = e;
         if (is_fetch) begin
            ee.ir_write = (k > wt);
            ee.pc_write = (k > wt);
         end
         if (k > wt) begin
            cyc(w, 1'b1, ee);
            ok = 1'b1;
            return;
         end
         cyc(w, 1'b0, ee);
         if (tmo[w] > 0 && k == tmo[w]) begin
            berr[w] = 1'b1;
            return;
         end
      end
   endtask

   task automatic alu_wb(input int w);
      exp_t e;
      e = base(w);
      e.reg_write = 1'b1;
      cyc(w, 1'($urandom_range(0, 1)), e);
      retire(w);
   endtask

   task automatic run_instr(input int w, input logic [6:0] op, input logic z,
                            input int fw, input int mw, output bit trapped);
      exp_t e;
      bit   ok;
      cur_op[w] = op;
      cur_z[w] = z;
      trapped = 1'b0;
      e = base(w); e.mem_req = 1'b1; e.asb = 2'b10; e.res = 2'b10;
      wait_phase(w, fw, e, 1'b1, ok);
      if (!ok) begin trapped = 1'b1; return; end
      e = base(w); e.asa = 2'b01; e.asb = 2'b01;
      cyc(w, 1'($urandom_range(0, 1)), e);
      case (op)
         7'd3, 7'd35: begin
            e = base(w); e.asa = 2'b10; e.asb = 2'b01;
            cyc(w, 1'($urandom_range(0, 1)), e);
            e = base(w); e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (op == 7'd35);
            wait_phase(w, mw, e, 1'b0, ok);
            if (!ok) begin trapped = 1'b1; return; end
            if (op == 7'd35) retire(w);
            else begin
               e = base(w); e.res = 2'b01; e.reg_write = 1'b1;
               cyc(w, 1'($urandom_range(0, 1)), e);
               retire(w);
            end
         end
         7'd51: begin
            e = base(w); e.asa = 2'b10; e.aluop = 2'b10;
            cyc(w, 1'($urandom_range(0, 1)), e);
            alu_wb(w);
         end
         7'd19: begin
            e = base(w); e.asa = 2'b10; e.asb = 2'b01; e.aluop = 2'b10;
            cyc(w, 1'($urandom_range(0, 1)), e);
            alu_wb(w);
         end
         7'd99: begin
            e = base(w); e.asa = 2'b10; e.aluop = 2'b01; e.pc_write = z;
            cyc(w, 1'($urandom_range(0, 1)), e);
            retire(w);
         end
         7'd111: begin
            e = base(w); e.asa = 2'b01; e.asb = 2'b10; e.pc_write = 1'b1;
            cyc(w, 1'($urandom_range(0, 1)), e);
            alu_wb(w);
         end
         default: begin
            if (op == 7'd115 && csr_en[w]) begin
               e = base(w); e.res = 2'b11; e.reg_write = 1'b1; e.csr_we = 1'b1; e.mocsr = 2'b01;
               cyc(w, 1'($urandom_range(0, 1)), e);
               retire(w);
            end else begin
               ill[w] = 1'b1;
               trapped = 1'b1;
            end
         end
      endcase
   endtask

   task automatic trap_hold(input int w, input int n);
      for (int i = 0; i < n; i++) cyc(w, 1'($urandom_range(0, 1)), base(w));
   endtask

   task automatic drain(input int w);
      for (int i = 0; i < 20 && qsize(w) > 0; i++) @(negedge clk);
      if (qsize(w) > 0) begin
         n_checks++;
         $display("FAIL drain%0d pending=%0d required=0", w, qsize(w));
      end
   endtask

   task automatic reset_check(input int w, input string name);
      exp_t e;
      ret[w] = '0; ill[w] = 1'b0; berr[w] = 1'b0;
      e = base(w); e.mem_req = 1'b1; e.asb = 2'b10; e.res = 2'b10;
      check_exp(name, samp(w), e);
   endtask

   task automatic do_reset(input int w);
      drain(w);
      @(posedge clk);
      #1;
      drive(w, 1'b0);
      if (w == 0) rst_a = 1'b0; else rst_b = 1'b0;
      #1;
      reset_check(w, $sformatf("reset%0d", w));
      @(posedge clk);
      #1;
      if (w == 0) rst_a = 1'b1; else rst_b = 1'b1;
   endtask

   task automatic memwrite_reset(input int w);
      exp_t e;
      cur_op[w] = 7'd35;
      e = base(w); e.mem_req = 1'b1; e.asb = 2'b10; e.res = 2'b10; e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc(w, 1'b1, e);
      e = base(w); e.asa = 2'b01; e.asb = 2'b01;
      cyc(w, 1'b0, e);
      e = base(w); e.asa = 2'b10; e.asb = 2'b01;
      cyc(w, 1'b0, e);
      e = base(w); e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1;
      drive(w, 1'b0);
      if (w == 0) qa.push_back(e); else qb.push_back(e);
      @(negedge clk);
      #2;
      if (w == 0) rst_a = 1'b0; else rst_b = 1'b0;
      #1;
      reset_check(w, "reset_mid_memwrite");
      @(posedge clk);
      #1;
      if (w == 0) rst_a = 1'b1; else rst_b = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      bit         tr;
      logic [6:0] ops[10] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd115, 7'h67, 7'h0f, 7'd51};
      ia.op = '0; ia.zero = 1'b0; ia.mem_ready = 1'b0;
      ib.op = '0; ib.zero = 1'b0; ib.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      do_reset(0);
      run_instr(0, 7'd51, 1'b0, 0, 0, tr);
      run_instr(0, 7'd3, 1'b0, 0, 3, tr);
      run_instr(0, 7'd99, 1'b1, 0, 0, tr);
      run_instr(0, 7'd99, 1'b0, 0, 0, tr);
      run_instr(0, 7'd35, 1'b0, 2, 1, tr);
      run_instr(0, 7'd111, 1'b0, 1, 0, tr);

      run_instr(0, 7'd51, 1'b0, TMO_A, 0, tr);
      check_val("timeout_trapped", 32'(tr), 32'd1);
      trap_hold(0, 5);
      do_reset(0);
      run_instr(0, 7'd51, 1'b0, TMO_A - 1, 0, tr);
      check_val("ready_on_last_cycle", 32'(tr), 32'd0);

      do_reset(0);
      for (int i = 0; i < 9; i++) run_instr(0, 7'd115, 1'b0, 0, 0, tr);
      drain(0);
      check_val("csr_instret_wrap", 32'(ia.instret), 32'd1);

      memwrite_reset(0);

      for (int i = 0; i < 150; i++) begin
         run_instr(0, ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? TMO_A : $urandom_range(0, 2),
                   ($urandom_range(0, 9) == 0) ? TMO_A : $urandom_range(0, 3), tr);
         if (tr) begin
            trap_hold(0, $urandom_range(1, 4));
            do_reset(0);
         end
      end
      drain(0);

      do_reset(1);
      run_instr(1, 7'd115, 1'b0, 0, 0, tr);
      check_val("csr_disabled_trap", 32'(tr), 32'd1);
      trap_hold(1, 10);
      do_reset(1);
      for (int i = 0; i < 60; i++) begin
         run_instr(1, ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 20), $urandom_range(0, 20), tr);
         if (tr) begin
            trap_hold(1, $urandom_range(1, 4));
            do_reset(1);
         end
      end
      drain(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control unit. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks.
- It handles a ready/request memory handshake with a configurable timeout, an optional CSR path, and illegal-opcode halting, and it counts retired instructions.
- It sits between the instruction register/ALU datapath and the shared instruction/data memory port.

Parameters:
- ENABLE_CSR, 1, 1 decodes opcode 115 as CSR; 0 treats opcode 115 as illegal.
- MEM_TIMEOUT, 16, maximum wait cycles per memory access; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  the requested access is a write.
- adr_src  out  1  0 = PC, 1 = ALUOut drives the memory address.
- ir_write  out  1  load the instruction register and old PC.
- pc_write  out  1  PC load enable: pc_update | (branch & zero).
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- inm_src  out  2  immediate format: I = 00, S = 01, B = 10, J = 11; decoded combinationally from op.
- res_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result, 11 = CSR read data.
- reg_write  out  1  register file write enable.
- csr_we  out  1  CSR write enable.
- mocsr  out  2  CSR operation mode: 01 while in the CSR state, otherwise 00.
- illegal  out  1  sticky flag: unsupported opcode.
- bus_err  out  1  sticky flag: memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Outputs are a function of the state register only (Moore), except inm_src (from op) and pc_write (uses zero). Any output not listed for a state is 0.
- Reset (async, rst_n = 0):
  - State goes to FETCH; instret, illegal, bus_err and the wait counter clear to 0.
  - During reset the outputs show FETCH values: mem_req = 1, alu_src_b = 10, res_src = 10, everything else 0.
- FETCH:
  - mem_req = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, res_src = 10.
  - When mem_ready = 1: ir_write = 1, pc_update = 1, next state DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (computes the branch/jump target). Next state by op:
  - 3 or 35 -> MEMADR
  - 51 -> EXECR
  - 19 -> EXECI
  - 99 -> BEQ
  - 111 -> JAL
  - 115 -> CSR if ENABLE_CSR = 1, else TRAP
  - any other value -> TRAP
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state: op 3 -> MEMREAD, op 35 -> MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then MEMWB.
- MEMWB: res_src = 01, reg_write = 1, retire, then FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. On mem_ready: retire, then FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10, then ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10, then ALUWB.
- ALUWB: res_src = 00, reg_write = 1, retire, then FETCH.
- BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, res_src = 00, branch = 1, so pc_write = zero. Retire, then FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, res_src = 00, pc_update = 1, then ALUWB (writes oldPC + 4 to rd).
- CSR: res_src = 11, reg_write = 1, csr_we = 1, mocsr = 01, retire, then FETCH.
- TRAP: all write enables and mem_req are 0. State holds until reset. illegal = 1 if entered from DECODE; bus_err = 1 if entered on timeout.
- Timeout (only when MEM_TIMEOUT > 0):
  - The wait counter clears on entry to FETCH, MEMREAD or MEMWRITE and increments each cycle mem_ready = 0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP and bus_err sets.
  - If mem_ready = 1 on that same cycle, the access completes and no error is raised.
- Retire: instret increments by 1 in each retire cycle and wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Zero-wait latencies:
  - R-type, I-type, sw, jal: 4 cycles
  - lw: 5 cycles
  - beq, CSR: 3 cycles

Test Plan:
- Zero-wait R-type (op = 51) after reset: states FETCH, DECODE, EXECR, ALUWB; reg_write = 1 in cycle 4 only; instret = 1.
- lw with mem_ready low for 3 cycles in MEMREAD: total 8 cycles; reg_write with res_src = 01 in the last cycle; adr_src = 1 throughout MEMREAD.
- beq with zero = 1, then with zero = 0: pc_write = 1 in BEQ for the first, 0 for the second; both take 3 cycles and instret += 2.
- op = 115 with ENABLE_CSR = 0 -> TRAP, illegal = 1 and held for 10 cycles, no mem_req; rst_n pulse returns to FETCH with illegal = 0.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, bus_err = 1. Same setup with mem_ready = 1 on the 4th cycle -> DECODE, no error.
- CNT_W = 3, 9 back-to-back CSR instructions -> instret = 1; rst_n asserted mid-MEMWRITE -> immediately FETCH, mem_write = 0.
